// File: rtl/join_sync_param.sv
// join_sync_param: clocked N-way join with per-channel token slots, runtime enable mask and full-throughput bypass
// Ports:
//   clk, rst (async, active-low)
//   req_in/ack_in/data_in : per-channel input handshakes, channel i data at [i*width +: width]
//   en_mask               : channels taking part in the join, sampled combinationally
//   req_out/ack_out       : joined token handshake carrying data_out and mask_out
//   timeout/timeout_clr   : sticky stall flag and its synchronous clear
// Optional feature macro: JOIN_TIMEOUT_EN builds the stall counter; otherwise timeout is tied to 0.
module join_sync_param #(
  parameter int size = 2,
  parameter int width = 8,
  parameter int timeout_cycles = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [size-1:0]         req_in,
  output logic [size-1:0]         ack_in,
  input  logic [size*width-1:0]   data_in,
  input  logic [size-1:0]         en_mask,
  output logic                    req_out,
  input  logic                    ack_out,
  output logic [size*width-1:0]   data_out,
  output logic [size-1:0]         mask_out,
  output logic                    timeout,
  input  logic                    timeout_clr
);
  logic [size-1:0] tok_q, tok_d, xfer, drain;
  logic [size*width-1:0] dat_q, dat_d, data_out_q, data_out_d;
  logic [size-1:0] mask_out_q, mask_out_d;
  logic out_vld_q, out_vld_d, fire;
  always_comb begin
    fire = (|en_mask) & (&(tok_q | ~en_mask)) & (~out_vld_q | ack_out);
    drain = {size{fire}} & en_mask;
    // a slot emptied by this cycle's fire may refill on the same edge
    ack_in = {size{rst}} & (~tok_q | drain);
    xfer = req_in & ack_in;
    tok_d = (tok_q & ~drain) | xfer;
    out_vld_d = fire | (out_vld_q & ~ack_out);
    mask_out_d = fire ? en_mask : mask_out_q;
    dat_d = dat_q;
    data_out_d = data_out_q;
    for (int i = 0; i < size; i++) begin
      if (xfer[i]) dat_d[i*width +: width] = data_in[i*width +: width];
      if (fire) data_out_d[i*width +: width] = en_mask[i] ? dat_q[i*width +: width] : '0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tok_q <= '0;
      dat_q <= '0;
      out_vld_q <= 1'b0;
      data_out_q <= '0;
      mask_out_q <= '0;
    end else begin
      tok_q <= tok_d;
      dat_q <= dat_d;
      out_vld_q <= out_vld_d;
      data_out_q <= data_out_d;
      mask_out_q <= mask_out_d;
    end
  assign req_out = out_vld_q;
  assign data_out = data_out_q;
  assign mask_out = mask_out_q;
`ifdef JOIN_TIMEOUT_EN
  localparam int cw = $clog2(timeout_cycles + 1);
  localparam logic [cw-1:0] tmax = cw'(timeout_cycles);
  logic [cw-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  always_comb begin
    cnt_d = (fire | ~|(tok_q & en_mask)) ? '0 : (cnt_q == tmax ? cnt_q : cnt_q + 1'b1);
    timeout_d = ~timeout_clr & (timeout_q | (cnt_d == tmax));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  assign timeout = timeout_q;
`else
  localparam int unused_timeout_cycles = timeout_cycles;
  logic unused_clr;
  assign unused_clr = timeout_clr;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_join_sync_param.sv
// tb_join_sync_param: directed self-checking bench for join_sync_param (size=2, width=8, timeout_cycles=4)
module tb_join_sync_param;
  logic clk = 1'b0;
  logic rst, ack_out, timeout_clr, req_out, timeout;
  logic [1:0] req_in, ack_in, en_mask, mask_out;
  logic [15:0] data_in, data_out;
  int errors = 0;
  int checks = 0;
  join_sync_param #(.size(2), .width(8), .timeout_cycles(4)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in), .data_in(data_in),
    .en_mask(en_mask), .req_out(req_out), .ack_out(ack_out), .data_out(data_out),
    .mask_out(mask_out), .timeout(timeout), .timeout_clr(timeout_clr)
  );
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b0; req_in = 2'b00; data_in = '0; en_mask = 2'b11; ack_out = 1'b1; timeout_clr = 1'b0;
    #12;
    checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL rst_req_out: got %b exp 0", req_out); end
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rst_data_out: got %h exp 0000", data_out); end
    checks++; if (mask_out !== 2'b00) begin errors++; $display("FAIL rst_mask_out: got %b exp 00", mask_out); end
    checks++; if (ack_in !== 2'b00) begin errors++; $display("FAIL rst_ack_in: got %b exp 00", ack_in); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b exp 0", timeout); end
    rst = 1'b1;
    #1;
    checks++; if (ack_in !== 2'b11) begin errors++; $display("FAIL rst_rel_ack_in: got %b exp 11", ack_in); end
    checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL rst_rel_req_out: got %b exp 0", req_out); end
    cyc;
  endtask
  task automatic test_basic;
    en_mask = 2'b11; ack_out = 1'b1;
    req_in = 2'b01; data_in = 16'h00A5;
    cyc;
    req_in = 2'b00;
    for (int c = 2; c <= 4; c++) begin
      #1;
      checks++; if (ack_in[0] !== 1'b0) begin errors++; $display("FAIL basic_ack0_c%0d: got %b exp 0", c, ack_in[0]); end
      if (c == 4) begin req_in = 2'b10; data_in = 16'h3C00; end
      cyc;
    end
    req_in = 2'b00;
    checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL basic_latency: got req_out %b exp 0", req_out); end
    cyc;
    checks++; if (req_out !== 1'b1) begin errors++; $display("FAIL basic_req_out: got %b exp 1", req_out); end
    checks++; if (data_out !== 16'h3CA5) begin errors++; $display("FAIL basic_data: got %h exp 3ca5", data_out); end
    checks++; if (mask_out !== 2'b11) begin errors++; $display("FAIL basic_mask: got %b exp 11", mask_out); end
    cyc;
    checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b exp 0", req_out); end
  endtask
  task automatic test_streaming;
    logic [7:0] k;
    en_mask = 2'b11; ack_out = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      k = 8'(e - 1);
      req_in = (e <= 20) ? 2'b11 : 2'b00;
      data_in = {k + 8'h80, k};
      cyc;
      if (e >= 2 && e <= 21) begin
        k = 8'(e - 2);
        checks++;
        if ({req_out, data_out} !== {1'b1, k + 8'h80, k}) begin
          errors++; $display("FAIL stream_tok%0d: got vld %b data %h exp vld 1 data %h", e - 2, req_out, data_out, {k + 8'h80, k});
        end
      end
    end
    checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL stream_end: got req_out %b exp 0", req_out); end
  endtask
  task automatic test_back_pressure;
    en_mask = 2'b11; ack_out = 1'b0;
    req_in = 2'b11; data_in = 16'h0201;
    cyc;
    data_in = 16'h0403;
    cyc;
    checks++; if ({req_out, data_out} !== {1'b1, 16'h0201}) begin errors++; $display("FAIL bp_first: got vld %b data %h exp vld 1 data 0201", req_out, data_out); end
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (ack_in !== 2'b00) begin errors++; $display("FAIL bp_ack_in_%0d: got %b exp 00", c, ack_in); end
      checks++; if ({data_out, mask_out} !== {16'h0201, 2'b11}) begin errors++; $display("FAIL bp_hold_%0d: got data %h mask %b exp 0201 11", c, data_out, mask_out); end
      cyc;
    end
    ack_out = 1'b1; data_in = 16'h0605;
    #1;
    checks++; if (ack_in !== 2'b11) begin errors++; $display("FAIL bp_release_ack: got %b exp 11", ack_in); end
    cyc;
    req_in = 2'b00;
    checks++; if ({req_out, data_out} !== {1'b1, 16'h0403}) begin errors++; $display("FAIL bp_drain1: got vld %b data %h exp vld 1 data 0403", req_out, data_out); end
    cyc;
    checks++; if ({req_out, data_out} !== {1'b1, 16'h0605}) begin errors++; $display("FAIL bp_drain2: got vld %b data %h exp vld 1 data 0605", req_out, data_out); end
    cyc;
    checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b exp 0", req_out); end
  endtask
  task automatic test_masking;
    ack_out = 1'b1; en_mask = 2'b01;
    req_in = 2'b11; data_in = 16'h7711;
    cyc;
    req_in = 2'b00;
    cyc;
    checks++; if ({req_out, data_out, mask_out} !== {1'b1, 16'h0011, 2'b01}) begin errors++; $display("FAIL mask01_out: got vld %b data %h mask %b exp 1 0011 01", req_out, data_out, mask_out); end
    checks++; if (ack_in !== 2'b01) begin errors++; $display("FAIL mask01_ch1_held: got ack_in %b exp 01", ack_in); end
    en_mask = 2'b11; req_in = 2'b01; data_in = 16'h0022;
    cyc;
    req_in = 2'b00;
    cyc;
    checks++; if ({req_out, data_out, mask_out} !== {1'b1, 16'h7722, 2'b11}) begin errors++; $display("FAIL mask11_out: got vld %b data %h mask %b exp 1 7722 11", req_out, data_out, mask_out); end
    en_mask = 2'b00; req_in = 2'b11; data_in = 16'h9988;
    cyc;
    req_in = 2'b00;
    for (int c = 0; c < 4; c++) begin
      cyc;
      checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL mask00_nofire_%0d: got req_out %b exp 0", c, req_out); end
    end
    checks++; if (ack_in !== 2'b00) begin errors++; $display("FAIL mask00_held: got ack_in %b exp 00", ack_in); end
    en_mask = 2'b11;
    cyc;
    checks++; if ({req_out, data_out, mask_out} !== {1'b1, 16'h9988, 2'b11}) begin errors++; $display("FAIL mask_reenable: got vld %b data %h mask %b exp 1 9988 11", req_out, data_out, mask_out); end
    cyc;
  endtask
  task automatic test_timeout;
    en_mask = 2'b11; ack_out = 1'b1;
    req_in = 2'b01; data_in = 16'h0055;
    cyc;
    req_in = 2'b00;
    cyc; cyc; cyc;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b exp 0", timeout); end
    cyc;
`ifdef JOIN_TIMEOUT_EN
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_set: got %b exp 1", timeout); end
    cyc;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b exp 1", timeout); end
`else
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_disabled: got %b exp 0", timeout); end
    cyc;
`endif
    timeout_clr = 1'b1; req_in = 2'b10; data_in = 16'h6600;
    cyc;
    timeout_clr = 1'b0; req_in = 2'b00;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b exp 0", timeout); end
    cyc;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_after_fire: got %b exp 0", timeout); end
    checks++; if ({req_out, data_out} !== {1'b1, 16'h6655}) begin errors++; $display("FAIL to_join: got vld %b data %h exp 1 6655", req_out, data_out); end
    cyc;
  endtask
  task automatic test_reset_mid;
    en_mask = 2'b11; ack_out = 1'b0;
    req_in = 2'b11; data_in = 16'hBEEF;
    cyc; cyc;
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({req_out, data_out, mask_out} !== {1'b0, 16'h0000, 2'b00}) begin errors++; $display("FAIL mid_rst_out: got vld %b data %h mask %b exp 0 0000 00", req_out, data_out, mask_out); end
    checks++; if (ack_in !== 2'b00) begin errors++; $display("FAIL mid_rst_ack: got %b exp 00", ack_in); end
    req_in = 2'b00; ack_out = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (ack_in !== 2'b11) begin errors++; $display("FAIL mid_rel_ack: got %b exp 11", ack_in); end
    cyc;
    checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL mid_rel_req: got %b exp 0", req_out); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_streaming;
    test_back_pressure;
    test_masking;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/join_sync_param.md
# join_sync_param

Clocked, parametrised N-way join with per-channel token buffering and a runtime channel-enable mask. Each input channel deposits one token, with data, into a holding slot. When every enabled channel holds a token, the block emits one joined token carrying all channel data on a single output handshake. It is the synchronous successor of the Muller-gate join and is used where request merging must run in the clocked domain with data attached and full throughput.

## Interface
- `size`, default 2: number of input channels, ≥2.
- `width`, default 8: data bits per channel, ≥1.
- `timeout_cycles`, default 255: stall threshold, ≥1; used only with `JOIN_TIMEOUT_EN`.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_in` input `size`: per-channel request (valid).
- `ack_in` output `size`: per-channel acknowledge (ready).
- `data_in` input `size*width`: channel i occupies bits `[i*width +: width]`.
- `en_mask` input `size`: channel enables; a 1 means the channel takes part in the join.
- `req_out` output 1: joined token valid.
- `ack_out` input 1: downstream acknowledge.
- `data_out` output `size*width`: joined data.
- `mask_out` output `size`: `en_mask` value used for the token currently on the output.
- `timeout` output 1: sticky stall flag.
- `timeout_clr` input 1: synchronous clear of `timeout`.

## Operation
- A transfer on any handshake occurs at a rising edge when req and ack are both high.
- **Per-channel slot:**
  - Holds a token flag `tok[i]` and a data register `dat[i]`.
  - Input transfer sets `tok[i]=1` and `dat[i]=data_in` slice.
- **Output register:** `out_vld`, `data_out`, `mask_out`, with `req_out = out_vld`.
- **Fire condition:** `fire = (en_mask != 0) & &(tok | ~en_mask) & (~out_vld | ack_out)`.
- **On fire:**
  - `out_vld <= 1`.
  - `data_out` slice i `<= dat[i]` if `en_mask[i]`, else 0.
  - `mask_out <= en_mask`.
  - `tok[i] <= 0` for every enabled channel.
- If `out_vld & ack_out & ~fire`, then `out_vld <= 0`. `data_out` and `mask_out` hold their values.
- **Acknowledge:**
  - `ack_in[i] = rst & (~tok[i] | (fire & en_mask[i]))`.
  - A slot drained by fire can accept a new token on the same edge (bypass), giving one join per cycle.
  - There is a combinational path from `ack_out` and `en_mask` to `ack_in`.
- **Disabled channels:**
  - A channel with `en_mask[i]=0` keeps its token untouched. Its held token is neither consumed nor discarded.
  - It continues to accept one token if its slot is empty.
  - The token takes part in the next fire after the channel is re-enabled.
- `en_mask` is sampled combinationally each cycle. There is no registering.
- An all-zero mask never fires.
- **Data:** `data_out` is a pure copy with no arithmetic. Bit order of `data_out` matches `data_in`.

## Timing
- **Reset values:**
  - `req_out=0`, `data_out=0`, `mask_out=0`, `timeout=0`.
  - All `tok=0`, all `dat=0`.
  - `ack_in=0` while `rst` is low.
- **Reset mid-operation:** all buffered and output tokens are lost. After reset is released, `ack_in` returns to all ones on the same cycle.
- **Latency:** if the last missing enabled token transfers at edge E0, `req_out` is high after edge E0+1.
- **Throughput:** one joined token per cycle while all enabled channels stream and `ack_out` is held at 1.
- **Output stability:** while `req_out=1 & ack_out=0`, `data_out` and `mask_out` are stable and no fire occurs.

## Configuration
- **`JOIN_TIMEOUT_EN` defined:**
  - A `$clog2(timeout_cycles+1)`-bit counter increments each cycle in which any enabled channel holds a token and fire is 0.
  - The counter clears on fire, or when no enabled channel holds a token.
  - When the counter reaches `timeout_cycles`, `timeout` is set to 1. It stays set until a cycle with `timeout_clr=1`, which clears it at that edge.
  - If set and clear coincide, clear wins.
  - The counter saturates at `timeout_cycles`.
- **`JOIN_TIMEOUT_EN` undefined:**
  - The counter is not built.
  - The `timeout` port still exists and is tied to 0.
  - `timeout_clr` is ignored.

## Test plan
- **Reset:** assert `rst=0` mid-traffic → all outputs 0 and `ack_in=0` immediately. After release, `ack_in=2'b11` and `req_out=0`.
- **Basic join:** size=2, width=8, mask=2'b11. Ch0 sends 0xA5 at edge 1; ch1 sends 0x3C at edge 4 → `req_out` rises after edge 5 with `data_out=16'h3CA5` and `mask_out=2'b11`. `ack_in[0]=0` during cycles 2–4.
- **Streaming:** both channels present incrementing data every cycle with `ack_out=1` for 20 cycles → 20 joined tokens with no gaps and no loss or duplication.
- **Back-pressure:** `ack_out=0` for 5 cycles while both slots are full → `data_out` stable and `ack_in=2'b00`. `ack_out=1` → the output drains and both slots are accepted on that edge.
- **Masking:** mask=2'b01. Ch1 holds 0x77 and ch0 sends 0x11 → output `16'h0011`, `mask_out=2'b01`, and ch1 keeps its token. Then mask=2'b11 and ch0 sends 0x22 → output `16'h7722`. With mask=2'b00, no fire ever occurs.
- **Timeout (`JOIN_TIMEOUT_EN`, `timeout_cycles=4`):** only ch0 holds a token → `timeout=1` after 4 stalled cycles. `timeout_clr` pulse → 0. Without the macro, `timeout` stays 0.
